// File: rtl/id_ex_pipe_pkg.sv
// Shared types and helpers for the ID/EX pipeline register.
// Core-wide defines are guarded so an RV32I_defines.v compiled earlier takes precedence.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif
`ifndef RFREG_NUM
`define RFREG_NUM 32
`endif
`ifndef CTRL_WIDTH
`define CTRL_WIDTH 16
`endif
`ifndef LOAD_USE_HAZARD_EN
`define LOAD_USE_HAZARD_EN 1
`endif

package id_ex_pipe_pkg;

  localparam int XLEN        = `XLEN;
  localparam int RFIDX_W     = `RFIDX_WIDTH;
  localparam int CTRL_WIDTH  = `CTRL_WIDTH;
  localparam bit LOAD_USE_EN = `LOAD_USE_HAZARD_EN;
  localparam int PERF_W      = 32;

  typedef logic [RFIDX_W-1:0] rfidx_t;

  // What the EX register does on the coming edge, in priority order.
  typedef enum logic [1:0] {
    UPD_FLUSH,
    UPD_HOLD,
    UPD_BUBBLE,
    UPD_LOAD
  } upd_e;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/id_ex_hazard.sv
// Load-use hazard detector: EX holds a load whose destination the decode instruction reads.
module id_ex_hazard
  import id_ex_pipe_pkg::*;
(
  input  logic   ex_valid,
  input  logic   ex_is_load,
  input  logic   ex_rd_we,
  input  rfidx_t ex_rd,
  input  logic   id_valid,
  input  logic   id_use_rs1,
  input  rfidx_t id_rs1,
  input  logic   id_use_rs2,
  input  rfidx_t id_rs2,
  output logic   load_use
);

  logic rs_match;

  assign rs_match = (id_use_rs1 && (id_rs1 == ex_rd)) ||
                    (id_use_rs2 && (id_rs2 == ex_rd));

  // x0 is never a real producer, so it can never cause a stall.
  assign load_use = LOAD_USE_EN && ex_valid && ex_is_load && ex_rd_we &&
                    (ex_rd != '0) && id_valid && rs_match;

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion, backpressure and flush.
// Optional saturating perf counters (perf_bubbles, perf_holds) under ID_EX_PERF_CNT_EN.
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int CTRL_W = 16,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [PC_W-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rd1,
  input  logic [XLEN-1:0]   id_rd2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [RFIDX_W-1:0] id_rs1,
  input  logic [RFIDX_W-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [RFIDX_W-1:0] id_rd,
  input  logic              id_rd_we,
  input  logic              id_is_load,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              ex_ready,
  input  logic              ex_flush,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [PC_W-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rd1,
  output logic [XLEN-1:0]   ex_rd2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [RFIDX_W-1:0] ex_rs1,
  output logic [RFIDX_W-1:0] ex_rs2,
  output logic [RFIDX_W-1:0] ex_rd,
  output logic              ex_rd_we,
  output logic              ex_is_load,
  output logic [CTRL_W-1:0] ex_ctrl
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_bubbles,
  output logic [PERF_W-1:0] perf_holds
`endif
);

  logic load_use;
  upd_e upd;

  id_ex_hazard u_hazard (
    .ex_valid   (ex_valid),
    .ex_is_load (ex_is_load),
    .ex_rd_we   (ex_rd_we),
    .ex_rd      (ex_rd),
    .id_valid   (id_valid),
    .id_use_rs1 (id_use_rs1),
    .id_rs1     (id_rs1),
    .id_use_rs2 (id_use_rs2),
    .id_rs2     (id_rs2),
    .load_use   (load_use)
  );

  // NOTE: default assigned first, so no path through the block can infer a latch.
  always_comb begin
    upd = UPD_LOAD;
    if (ex_flush)      upd = UPD_FLUSH;
    else if (!ex_ready) upd = UPD_HOLD;
    else if (load_use) upd = UPD_BUBBLE;
  end

  // Gated by rst_n so decode never sees a stall while the core is in reset.
  assign id_stall = rst_n && (load_use || !ex_ready) && !ex_flush;

  // NOTE: non-blocking assignments so every flop samples pre-edge values;
  // the payload is a small flop bank, so it is reset along with ex_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_rd1     <= '0;
      ex_rd2     <= '0;
      ex_imm     <= '0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_rd      <= '0;
      ex_rd_we   <= 1'b0;
      ex_is_load <= 1'b0;
      ex_ctrl    <= '0;
    end else begin
      case (upd)
        UPD_FLUSH, UPD_BUBBLE: ex_valid <= 1'b0;
        UPD_HOLD:              ex_valid <= ex_valid;
        default: begin
          ex_valid   <= id_valid;
          ex_pc      <= id_pc;
          ex_rd1     <= id_rd1;
          ex_rd2     <= id_rd2;
          ex_imm     <= id_imm;
          ex_rs1     <= id_rs1;
          ex_rs2     <= id_rs2;
          ex_rd      <= id_rd;
          ex_rd_we   <= id_rd_we;
          ex_is_load <= id_is_load;
          ex_ctrl    <= id_ctrl;
        end
      endcase
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bubbles <= '0;
      perf_holds   <= '0;
    end else begin
      if (upd == UPD_BUBBLE) perf_bubbles <= sat_inc(perf_bubbles);
      if (upd == UPD_HOLD)   perf_holds   <= sat_inc(perf_holds);
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: directed scenarios plus random traffic
// compared against a transaction-level reference model.
module tb_id_ex_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2, id_rd_we, id_is_load;
  logic [15:0] id_ctrl;
  logic        ex_ready, ex_flush;
  logic        id_stall, ex_valid;
  logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        ex_rd_we, ex_is_load;
  logic [15:0] ex_ctrl;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] perf_bubbles, perf_holds;
`endif

  id_ex_pipe #(.CTRL_W(16), .PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_rd_we(id_rd_we), .id_is_load(id_is_load), .id_ctrl(id_ctrl),
    .ex_ready(ex_ready), .ex_flush(ex_flush), .id_stall(id_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load), .ex_ctrl(ex_ctrl)
`ifdef ID_EX_PERF_CNT_EN
    , .perf_bubbles(perf_bubbles), .perf_holds(perf_holds)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        use_rs1, use_rs2, rd_we, is_load;
    logic [15:0] ctrl;
    logic        ready, flush;
  } in_t;

  // Reference model: the instruction that EX is expected to hold.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        rd_we, is_load;
    logic [15:0] ctrl;
  } ex_t;

  ex_t         m;
  int unsigned m_bubbles, m_holds;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [191:0] dut_payload();
    return {31'd0, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
            ex_rd_we, ex_is_load, ex_ctrl};
  endfunction

  function automatic logic [191:0] model_payload();
    return {31'd0, m.pc, m.rd1, m.rd2, m.imm, m.rs1, m.rs2, m.rd,
            m.rd_we, m.is_load, m.ctrl};
  endfunction

  // A load in EX writes a real register that decode wants to read.
  function automatic bit must_wait(input in_t s);
    bit reads_it;
    reads_it = (s.use_rs1 && s.rs1 == m.rd) || (s.use_rs2 && s.rs2 == m.rd);
    return m.valid && m.is_load && m.rd_we && (m.rd != 5'd0) && s.valid && reads_it;
  endfunction

  function automatic bit exp_stall(input in_t s);
    return (must_wait(s) || !s.ready) && !s.flush;
  endfunction

  task automatic model_edge(input in_t s);
    if (s.flush) m.valid = 1'b0;
    else if (!s.ready) m_holds++;
    else if (must_wait(s)) begin
      m.valid = 1'b0;
      m_bubbles++;
    end else
      m = '{valid: s.valid, pc: s.pc, rd1: s.rd1, rd2: s.rd2, imm: s.imm,
            rs1: s.rs1, rs2: s.rs2, rd: s.rd, rd_we: s.rd_we,
            is_load: s.is_load, ctrl: s.ctrl};
  endtask

  task automatic drive(input in_t s);
    id_valid = s.valid;    id_pc = s.pc;        id_rd1 = s.rd1;
    id_rd2 = s.rd2;        id_imm = s.imm;      id_rs1 = s.rs1;
    id_rs2 = s.rs2;        id_rd = s.rd;        id_use_rs1 = s.use_rs1;
    id_use_rs2 = s.use_rs2; id_rd_we = s.rd_we; id_is_load = s.is_load;
    id_ctrl = s.ctrl;      ex_ready = s.ready;  ex_flush = s.flush;
  endtask

  // Called at a falling edge: drive, check the combinational stall, clock, check EX.
  task automatic cycle(input in_t s, input string tag);
    drive(s);
    #1;
    check({tag, "_stall"}, 192'(id_stall), 192'(exp_stall(s)));
    @(posedge clk);
    model_edge(s);
    @(negedge clk);
    check({tag, "_valid"}, 192'(ex_valid), 192'(m.valid));
    check({tag, "_payload"}, dut_payload(), model_payload());
  endtask

  function automatic in_t base(input logic [4:0] rd, input logic [31:0] tag);
    in_t s;
    s = '0;
    s.valid = 1'b1; s.ready = 1'b1; s.rd = rd; s.rd_we = 1'b1;
    s.pc = tag; s.rd1 = tag ^ 32'h1111_0000; s.rd2 = ~tag; s.imm = tag + 32'd4;
    s.ctrl = tag[15:0];
    return s;
  endfunction

  function automatic in_t rand_in();
    in_t s;
    s.valid = ($urandom_range(0, 9) != 0);
    s.pc = $urandom; s.rd1 = $urandom; s.rd2 = $urandom; s.imm = $urandom;
    s.rs1 = 5'($urandom_range(0, 3)); s.rs2 = 5'($urandom_range(0, 3));
    s.rd = 5'($urandom_range(0, 3));
    s.use_rs1 = 1'($urandom_range(0, 1)); s.use_rs2 = 1'($urandom_range(0, 1));
    s.rd_we = ($urandom_range(0, 3) != 0);
    s.is_load = 1'($urandom_range(0, 1));
    s.ctrl = 16'($urandom);
    s.ready = ($urandom_range(0, 4) != 0);
    s.flush = ($urandom_range(0, 9) == 0);
    return s;
  endfunction

  // Asserts reset part-way through a low clock phase and checks it acts at once.
  task automatic mid_cycle_reset(input string tag);
    in_t s;
    s = base(5'd9, 32'hDEAD_0000);
    s.ready = 1'b0;
    drive(s);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_valid"}, 192'(ex_valid), 192'd0);
    check({tag, "_payload"}, dut_payload(), 192'd0);
    check({tag, "_stall"}, 192'(id_stall), 192'd0);
    m = '0; m_bubbles = 0; m_holds = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t s, u;
    m = '0; m_bubbles = 0; m_holds = 0;
    rst_n = 1'b0;
    drive('0);
    #1;
    check("por_valid", 192'(ex_valid), 192'd0);
    check("por_payload", dut_payload(), 192'd0);
    check("por_stall", 192'(id_stall), 192'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Normal flow: one-cycle latency.
    s = base(5'd5, 32'h0000_1000);
    s.rd1 = 32'h1234_5678;
    cycle(s, "flow");
    check("flow_rd1_const", 192'(ex_rd1), 192'(32'h1234_5678));
    check("flow_rd_const", 192'(ex_rd), 192'(5'd5));
    check("flow_valid_const", 192'(ex_valid), 192'd1);

    // Reset asserted mid-cycle while EX holds a valid instruction.
    mid_cycle_reset("rst_mid");

    // Load-use on rs2 = 3: exactly one bubble, then the held instruction advances.
    s = base(5'd3, 32'h0000_2000); s.is_load = 1'b1;
    cycle(s, "ld_a");
    u = base(5'd7, 32'h0000_2004); u.use_rs2 = 1'b1; u.rs2 = 5'd3;
    drive(u); #1;
    check("lu_stall_const", 192'(id_stall), 192'd1);
    @(negedge clk);
    m.valid = 1'b0; m_bubbles++;
    check("lu_bubble", 192'(ex_valid), 192'd0);
    cycle(u, "lu_adv");
    check("lu_adv_rd", 192'(ex_rd), 192'(5'd7));
    check("lu_adv_stall", 192'(id_stall), 192'd0);

    // Same pattern with destination x0: no stall.
    s = base(5'd0, 32'h0000_3000); s.is_load = 1'b1;
    cycle(s, "ld_x0");
    u = base(5'd8, 32'h0000_3004); u.use_rs2 = 1'b1; u.rs2 = 5'd0;
    cycle(u, "x0_use");
    check("x0_valid_const", 192'(ex_valid), 192'd1);

    // Backpressure for three cycles, then the next instruction loads.
    s = base(5'd10, 32'h0000_4000);
    cycle(s, "bp_a");
    u = base(5'd11, 32'h0000_4004); u.ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle(u, $sformatf("bp_hold%0d", i));
    check("bp_held_rd", 192'(ex_rd), 192'(5'd10));
    u.ready = 1'b1;
    cycle(u, "bp_go");

    // Flush beats both a load-use hazard and backpressure.
    s = base(5'd3, 32'h0000_5000); s.is_load = 1'b1;
    cycle(s, "fl_ld");
    u = base(5'd12, 32'h0000_5004); u.use_rs1 = 1'b1; u.rs1 = 5'd3;
    u.ready = 1'b0; u.flush = 1'b1;
    cycle(u, "flush");
    check("flush_valid_const", 192'(ex_valid), 192'd0);

    // Two bubbles and three holds from a clean reset.
    mid_cycle_reset("rst_perf");
    for (int k = 0; k < 2; k++) begin
      s = base(5'd4, 32'h0000_6000 + 32'(k)); s.is_load = 1'b1;
      cycle(s, "pf_ld");
      u = base(5'd13, 32'h0000_6100 + 32'(k)); u.use_rs1 = 1'b1; u.rs1 = 5'd4;
      cycle(u, "pf_bub");
      cycle(u, "pf_adv");
    end
    u.ready = 1'b0;
    for (int k = 0; k < 3; k++) cycle(u, "pf_hold");
`ifdef ID_EX_PERF_CNT_EN
    check("perf_bubbles", 192'(perf_bubbles), 192'd2);
    check("perf_holds", 192'(perf_holds), 192'd3);
`endif

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) cycle(rand_in(), $sformatf("rnd%0d", n));
`ifdef ID_EX_PERF_CNT_EN
    check("rnd_perf_bubbles", 192'(perf_bubbles), 192'(m_bubbles));
    check("rnd_perf_holds", 192'(perf_holds), 192'(m_holds));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
